// File: rtl/wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : wm_cycle_controller
// Purpose : Command responder for the washing machine control interface.
//           Decodes 3-bit opcodes with an 8-bit operand and sequences the wash
//           program IDLE -> FILL -> WASH -> RINSE -> SPIN -> DONE. Pause,
//           resume and abort are supported. Progress is reported as the
//           remaining ticks of the current phase.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-high reset
//           ctrl     - command opcode, sampled every rising edge
//           data_in  - command operand (LOAD only)
//           data_out - remaining ticks in phase; wash_len in IDLE/DONE
//           status   - {busy, paused, done, err, zero, state[2:0]}
// Revision: 1.0 - initial release
// ============================================================================
module wm_cycle_controller #(
  parameter int unsigned FILL_TICKS  = 4,
  parameter int unsigned RINSE_TICKS = 4,
  parameter int unsigned SPIN_TICKS  = 3,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ctrl,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WASH   = 3'd2,
    S_RINSE  = 3'd3,
    S_SPIN   = 3'd4,
    S_DONE   = 3'd5,
    S_PAUSED = 3'd6
  } state_t;

  localparam logic [2:0] C_OP_LOAD   = 3'd1;
  localparam logic [2:0] C_OP_START  = 3'd2;
  localparam logic [2:0] C_OP_PAUSE  = 3'd3;
  localparam logic [2:0] C_OP_RESUME = 3'd4;
  localparam logic [2:0] C_OP_ABORT  = 3'd5;
  localparam logic [2:0] C_OP_CLRERR = 3'd6;
  localparam logic [2:0] C_OP_RSVD   = 3'd7;

  localparam logic [7:0]  C_FILL_LEN  = 8'(FILL_TICKS);
  localparam logic [7:0]  C_RINSE_LEN = 8'(RINSE_TICKS);
  localparam logic [7:0]  C_SPIN_LEN  = 8'(SPIN_TICKS);
  localparam logic [15:0] C_TICK_LAST = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  state_t      saved_q, saved_d;
  logic [7:0]  wash_len_q, wash_len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] presc_q, presc_d;
  logic        err_q, err_d;

  logic w_active;
  logic w_idle_done;
  logic w_tick;

  assign w_active    = (state_q == S_FILL) || (state_q == S_WASH) ||
                       (state_q == S_RINSE) || (state_q == S_SPIN);
  assign w_idle_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_tick      = w_active && (presc_q == C_TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      saved_q    <= S_IDLE;
      wash_len_q <= 8'd0;
      cnt_q      <= 8'd0;
      presc_q    <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      wash_len_q <= wash_len_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      err_q      <= err_d;
    end
  end

  // Tick processing is evaluated first; a state-changing command below then
  // overwrites state/cnt/prescaler, which is how the same-cycle tick is
  // discarded. Erroring commands only touch err, so the tick still lands.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    wash_len_d = wash_len_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    err_d      = err_q;

    if (w_active) begin
      if (w_tick) begin
        presc_d = 16'd0;
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          case (state_q)
            S_FILL:  begin state_d = S_WASH;  cnt_d = wash_len_q;  end
            S_WASH:  begin state_d = S_RINSE; cnt_d = C_RINSE_LEN; end
            S_RINSE: begin state_d = S_SPIN;  cnt_d = C_SPIN_LEN;  end
            S_SPIN:  begin state_d = S_DONE;  cnt_d = 8'd0;        end
            default: ;
          endcase
        end
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    case (ctrl)
      C_OP_LOAD: begin
        if (w_idle_done) wash_len_d = data_in;
        else             err_d      = 1'b1;
      end
      C_OP_START: begin
        if (w_idle_done && (wash_len_q != 8'd0)) begin
          state_d = S_FILL;
          cnt_d   = C_FILL_LEN;
          presc_d = 16'd0;
        end else begin
          err_d = 1'b1;
        end
      end
      C_OP_PAUSE: begin
        if (w_active) begin
          saved_d = state_q;
          state_d = S_PAUSED;
          cnt_d   = cnt_q;
          presc_d = presc_q;
        end else begin
          err_d = 1'b1;
        end
      end
      C_OP_RESUME: begin
        if (state_q == S_PAUSED) begin
          state_d = saved_q;
          cnt_d   = cnt_q;
          presc_d = 16'd0;
        end else begin
          err_d = 1'b1;
        end
      end
      C_OP_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        presc_d = 16'd0;
      end
      C_OP_CLRERR: err_d = 1'b0;
      C_OP_RSVD:   err_d = 1'b1;
      default: ;
    endcase
  end

  logic w_busy;
  logic w_zero;

  assign w_busy   = w_active || (state_q == S_PAUSED);
  // A busy phase should never show zero remaining ticks; this flags it.
  assign w_zero   = w_busy && (cnt_q == 8'd0);
  assign data_out = w_idle_done ? wash_len_q : cnt_q;
  assign status   = {w_busy, (state_q == S_PAUSED), (state_q == S_DONE),
                     err_q, w_zero, state_q};

endmodule
`default_nettype wire

// File: tb/tb_wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_wm_cycle_controller
// Purpose : Directed self-checking bench for wm_cycle_controller. One
//           instance uses default parameters, a second uses TICK_DIV=3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wm_cycle_controller;

  logic       clk;
  logic       rst;
  logic [2:0] ctrl, ctrl3;
  logic [7:0] data_in, data_in3;
  logic [7:0] data_out, data_out3;
  logic [7:0] status, status3;

  int checks;
  int failures;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, START = 3'd2, PAUSE = 3'd3,
                         RESUME = 3'd4, ABORT = 3'd5, CLRERR = 3'd6, RSVD = 3'd7;

  wm_cycle_controller dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .data_in(data_in),
    .data_out(data_out), .status(status)
  );

  wm_cycle_controller #(.TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .ctrl(ctrl3), .data_in(data_in3),
    .data_out(data_out3), .status(status3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: drive a command across one rising edge and
  // return at the next falling edge, where outputs are sampled.
  task automatic step(input logic [2:0] op, input logic [7:0] d);
    ctrl = op; data_in = d;
    @(negedge clk);
    ctrl = NOP; data_in = 8'd0;
  endtask

  task automatic step3(input logic [2:0] op, input logic [7:0] d);
    ctrl3 = op; data_in3 = d;
    @(negedge clk);
    ctrl3 = NOP; data_in3 = 8'd0;
  endtask

  task automatic test_reset();
    checks++;
    if (status !== 8'h00 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_init status=%h data_out=%h expected 00/00", status, data_out);
    end
    step(LOAD, 8'd3);
    step(START, 8'd0);
    step(NOP, 8'd0);
    // Async reset between edges
    #2 rst = 1'b1;
    #1;
    checks++;
    if (status !== 8'h00 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_async status=%h data_out=%h expected 00/00", status, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    step(NOP, 8'd0);
    checks++;
    if (status !== 8'h00 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_release status=%h data_out=%h expected 00/00", status, data_out);
    end
  endtask

  task automatic test_program();
    step(LOAD, 8'd5);
    checks++;
    if (status !== 8'h00 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL prog_load status=%h data_out=%h expected 00/05", status, data_out);
    end
    step(START, 8'd0);
    checks++;
    if (status !== 8'h81 || data_out !== 8'd4) begin
      failures++;
      $display("FAIL prog_fill status=%h data_out=%h expected 81/04", status, data_out);
    end
    repeat (3) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h81 || data_out !== 8'd1) begin
      failures++;
      $display("FAIL prog_fill_last status=%h data_out=%h expected 81/01", status, data_out);
    end
    step(NOP, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL prog_wash status=%h data_out=%h expected 82/05", status, data_out);
    end
    repeat (5) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h83 || data_out !== 8'd4) begin
      failures++;
      $display("FAIL prog_rinse status=%h data_out=%h expected 83/04", status, data_out);
    end
    repeat (4) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h84 || data_out !== 8'd3) begin
      failures++;
      $display("FAIL prog_spin status=%h data_out=%h expected 84/03", status, data_out);
    end
    repeat (2) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h84 || data_out !== 8'd1) begin
      failures++;
      $display("FAIL prog_spin_last status=%h data_out=%h expected 84/01", status, data_out);
    end
    step(NOP, 8'd0);
    checks++;
    if (status !== 8'h25 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL prog_done status=%h data_out=%h expected 25/05", status, data_out);
    end
  endtask

  // Restart from DONE, pause in WASH, resume, then abort in RINSE.
  task automatic test_pause_abort();
    step(START, 8'd0);
    repeat (4) step(NOP, 8'd0);
    repeat (2) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd3) begin
      failures++;
      $display("FAIL pause_pre status=%h data_out=%h expected 82/03", status, data_out);
    end
    step(PAUSE, 8'd0);
    checks++;
    if (status !== 8'hC6 || data_out !== 8'd3) begin
      failures++;
      $display("FAIL pause_enter status=%h data_out=%h expected C6/03", status, data_out);
    end
    for (int i = 0; i < 10; i++) begin
      step(NOP, 8'd0);
      checks++;
      if (status !== 8'hC6 || data_out !== 8'd3) begin
        failures++;
        $display("FAIL pause_hold[%0d] status=%h data_out=%h expected C6/03", i, status, data_out);
      end
    end
    step(RESUME, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd3) begin
      failures++;
      $display("FAIL resume status=%h data_out=%h expected 82/03", status, data_out);
    end
    repeat (2) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd1) begin
      failures++;
      $display("FAIL resume_last status=%h data_out=%h expected 82/01", status, data_out);
    end
    step(NOP, 8'd0);
    checks++;
    if (status !== 8'h83 || data_out !== 8'd4) begin
      failures++;
      $display("FAIL resume_rinse status=%h data_out=%h expected 83/04", status, data_out);
    end
    step(ABORT, 8'd0);
    checks++;
    if (status !== 8'h00 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL abort_rinse status=%h data_out=%h expected 00/05", status, data_out);
    end
    step(RSVD, 8'd0);
    checks++;
    if (status !== 8'h10 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL rsvd_err status=%h data_out=%h expected 10/05", status, data_out);
    end
    step(CLRERR, 8'd0);
    step(RESUME, 8'd0);
    checks++;
    if (status !== 8'h10) begin
      failures++;
      $display("FAIL resume_idle_err status=%h expected 10", status);
    end
    step(CLRERR, 8'd0);
    checks++;
    if (status !== 8'h00) begin
      failures++;
      $display("FAIL clr_err status=%h expected 00", status);
    end
  endtask

  task automatic test_errors();
    step(LOAD, 8'd0);
    step(START, 8'd0);
    checks++;
    if (status !== 8'h10 || data_out !== 8'd0) begin
      failures++;
      $display("FAIL start_zero status=%h data_out=%h expected 10/00", status, data_out);
    end
    step(CLRERR, 8'd0);
    checks++;
    if (status !== 8'h00) begin
      failures++;
      $display("FAIL start_zero_clr status=%h expected 00", status);
    end
    step(LOAD, 8'd5);
    step(START, 8'd0);
    repeat (4) step(NOP, 8'd0);
    step(LOAD, 8'd9);
    checks++;
    if (status !== 8'h92 || data_out !== 8'd4) begin
      failures++;
      $display("FAIL load_in_wash status=%h data_out=%h expected 92/04", status, data_out);
    end
    repeat (11) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h35 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL load_wash_done status=%h data_out=%h expected 35/05", status, data_out);
    end
    step(CLRERR, 8'd0);
    step(ABORT, 8'd0);
    checks++;
    if (status !== 8'h00 || data_out !== 8'd5) begin
      failures++;
      $display("FAIL abort_done status=%h data_out=%h expected 00/05", status, data_out);
    end
  endtask

  task automatic test_max_len();
    step(LOAD, 8'd255);
    step(START, 8'd0);
    repeat (4) step(NOP, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd255) begin
      failures++;
      $display("FAIL wash255 status=%h data_out=%h expected 82/FF", status, data_out);
    end
    step(NOP, 8'd0);
    checks++;
    if (status !== 8'h82 || data_out !== 8'd254) begin
      failures++;
      $display("FAIL wash255_dec status=%h data_out=%h expected 82/FE", status, data_out);
    end
    step(ABORT, 8'd0);
    checks++;
    if (status !== 8'h00 || data_out !== 8'd255) begin
      failures++;
      $display("FAIL wash255_abort status=%h data_out=%h expected 00/FF", status, data_out);
    end
  endtask

  task automatic test_tick_div();
    step3(LOAD, 8'd2);
    step3(START, 8'd0);
    checks++;
    if (status3 !== 8'h81 || data_out3 !== 8'd4) begin
      failures++;
      $display("FAIL div_fill status=%h data_out=%h expected 81/04", status3, data_out3);
    end
    repeat (11) step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h81 || data_out3 !== 8'd1) begin
      failures++;
      $display("FAIL div_fill_last status=%h data_out=%h expected 81/01", status3, data_out3);
    end
    step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h82 || data_out3 !== 8'd2) begin
      failures++;
      $display("FAIL div_wash status=%h data_out=%h expected 82/02", status3, data_out3);
    end
    repeat (5) step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h82 || data_out3 !== 8'd1) begin
      failures++;
      $display("FAIL div_wash_last status=%h data_out=%h expected 82/01", status3, data_out3);
    end
    step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h83 || data_out3 !== 8'd4) begin
      failures++;
      $display("FAIL div_rinse status=%h data_out=%h expected 83/04", status3, data_out3);
    end
    step3(ABORT, 8'd0);
    step3(START, 8'd0);
    repeat (11) step3(NOP, 8'd0);
    // PAUSE lands on the edge that would carry FILL's last tick
    step3(PAUSE, 8'd0);
    checks++;
    if (status3 !== 8'hC1 - 8'h01 + 8'h06 || data_out3 !== 8'd1) begin
      failures++;
      $display("FAIL div_pause status=%h data_out=%h expected C6/01", status3, data_out3);
    end
    repeat (2) step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'hC6 || data_out3 !== 8'd1) begin
      failures++;
      $display("FAIL div_pause_hold status=%h data_out=%h expected C6/01", status3, data_out3);
    end
    step3(RESUME, 8'd0);
    repeat (2) step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h81 || data_out3 !== 8'd1) begin
      failures++;
      $display("FAIL div_resume status=%h data_out=%h expected 81/01", status3, data_out3);
    end
    step3(NOP, 8'd0);
    checks++;
    if (status3 !== 8'h82 || data_out3 !== 8'd2) begin
      failures++;
      $display("FAIL div_resume_wash status=%h data_out=%h expected 82/02", status3, data_out3);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ctrl     = NOP; data_in  = 8'd0;
    ctrl3    = NOP; data_in3 = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_program();
    test_pause_abort();
    test_errors();
    test_max_len();
    test_tick_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
